div_iter: RTL
=============

# div_iter

Iterative 32-bit integer divider for the DIV/DIVU instructions. It runs a radix-2 restoring algorithm over 32 cycles, holds the quotient and remainder in registers, and raises a one-cycle completion pulse. Its outputs feed the HI/LO write-data 2:1 selectors directly, which choose between divider results and multiplier or MTHI/MTLO data. The pipeline controller stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported for the CPU build; the value is parameterised for the bench.
- `clk` input 1: core clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: single-cycle request to begin a division; only accepted in IDLE or DONE.
- `is_signed` input 1: 1 selects DIV (two's complement), 0 selects DIVU. Sampled with `start`.
- `dividend` input WIDTH: rs operand, sampled with `start`.
- `divisor` input WIDTH: rt operand, sampled with `start`.
- `busy` output 1: high while in CALC or FIX.
- `done` output 1: one-cycle pulse; results are valid from this cycle onward.
- `quotient` output WIDTH: registered; goes to LO.
- `remainder` output WIDTH: registered; goes to HI.
- `div_zero` output 1: present only with `DIV_ZERO_FAST_EN`; high together with `done` when the divisor was 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE/DONE + start**
  - Latch the operand magnitudes. For signed operands use the absolute values.
  - Latch the quotient sign (sign(dividend) XOR sign(divisor)) and the remainder sign (sign(dividend)).
  - Clear the partial remainder, set the iteration counter to 0, go to CALC.
- **CALC** (one step per cycle):
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor magnitude at WIDTH+1 bits.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - After the counter reaches WIDTH-1, go to FIX.
- **FIX**
  - Apply the signs: negate the quotient if the quotient sign is 1, negate the remainder if the remainder sign is 1.
  - Register the results into `quotient`/`remainder`, go to DONE.
- **DONE**
  - `done`=1 for exactly this cycle.
  - Go to IDLE unless `start` is asserted, in which case go straight to CALC.
- **`start` while busy:** ignored; the in-flight operation and its operands are unaffected.
- **Result holding:** `quotient`/`remainder` change only in FIX (or in the zero-divisor path below) and otherwise hold until the next result is written.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0. The natural algorithm produces this with WIDTH+1-bit magnitudes; no special case is needed.
- **Divide by zero:** quotient 0xFFFFFFFF and remainder equal to the original dividend, in both signed and unsigned modes. The FIX step forces these values and ignores the sign correction.
- Sign of a non-zero remainder always equals the dividend sign; the quotient truncates toward zero.

## Timing
- **Reset values** (asynchronous, on `rst_n`=0): state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_zero`=0, all internal registers 0.
- **Latency:** with `start` sampled at edge N:
  - CALC occupies cycles N+1 .. N+32.
  - FIX occupies cycle N+33.
  - `done`=1 during cycle N+34, with results visible in the same cycle.
- `busy` is high during cycles N+1 .. N+33 and is low in the `done` cycle.
- **Throughput:** back-to-back divisions are possible with `start` asserted in the DONE cycle, giving one result every 34 cycles.
- **Reset during CALC/FIX:** the operation is abandoned, no `done` pulse is produced, and outputs return to 0.

## Configuration
- `DIV_ZERO_FAST_EN` defined:
  - A zero divisor is detected at `start`.
  - The block goes directly to DONE at N+1, with `done`=1 and `div_zero`=1 during cycle N+1.
  - Results are the divide-by-zero values above; `busy` never rises.
- `DIV_ZERO_FAST_EN` undefined:
  - No `div_zero` port.
  - A zero divisor takes the full 34-cycle path and produces the same forced results.

## Test plan
- **Unsigned divide:** DIVU 100 / 7 with `start` at edge 0 -> `busy` high for cycles 1..33, `done` in cycle 34, quotient 14, remainder 2.
- **Signed divide:** DIV 0xFFFFFFF9 (-7) / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. DIVU with the same operands -> quotient 0, remainder 0x80000000.
- **Divide by zero:** 0x12345678 / 0 -> quotient 0xFFFFFFFF, remainder 0x12345678.
  - With the macro: `done` and `div_zero` high at cycle 1.
  - Without the macro: `done` at cycle 34.
- **Start while busy:** DIVU 50 / 5 started, then a second `start` with 9 / 3 at cycle 10 -> ignored; result quotient 10, remainder 0 at cycle 34. A `start` with 9 / 3 held in that DONE cycle -> quotient 3, remainder 0 at cycle 68.
- **Reset mid-operation:** `rst_n` low at cycle 15 -> immediately `busy`=0 and outputs 0, no `done` pulse. A new DIVU 9 / 4 started afterwards -> quotient 2, remainder 1 with the standard 34-cycle latency.

Source files
------------

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU: 32 CALC steps, one FIX step, one-cycle done pulse.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes in one cycle and raises div_zero.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FAST_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] dvd_orig;
    logic             q_neg;
    logic             r_neg;
    logic             dvs_zero;

    logic             accept;
    logic             fast_zero;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             trial_ok;

    function automatic logic [WIDTH-1:0] abs_mag(input logic signed [WIDTH-1:0] v,
                                                 input logic en);
        return (en && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic signed [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? WIDTH'(-v) : v;
    endfunction

    assign accept = start && ((state == IDLE) || (state == DONE));

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = (divisor == '0);
    assign div_zero  = (state == DONE) && dvs_zero;
`else
    assign fast_zero = 1'b0;
`endif

    // Trial subtract: the difference is only kept when it is below the divisor, so WIDTH bits suffice.
    assign shifted  = {rem_acc, quo_acc[WIDTH-1]};
    assign trial_ok = (shifted >= {1'b0, dvs_mag});
    assign diff     = shifted[WIDTH-1:0] - dvs_mag;

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = fast_zero ? DONE : CALC;
            CALC:    if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? (fast_zero ? DONE : CALC) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_acc   <= '0;
            quo_acc   <= '0;
            dvs_mag   <= '0;
            dvd_orig  <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            dvs_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                quo_acc  <= abs_mag(dividend, is_signed);
                dvs_mag  <= abs_mag(divisor, is_signed);
                q_neg    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg    <= is_signed && dividend[WIDTH-1];
                dvd_orig <= dividend;
                dvs_zero <= (divisor == '0);
                rem_acc  <= '0;
                cnt      <= '0;
                if (fast_zero) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (state == CALC) begin
                rem_acc <= trial_ok ? diff : shifted[WIDTH-1:0];
                quo_acc <= {quo_acc[WIDTH-2:0], trial_ok};
                cnt     <= cnt + 1'b1;
            end else if (state == FIX) begin
                if (dvs_zero) begin
                    quotient  <= '1;
                    remainder <= dvd_orig;
                end else begin
                    quotient  <= cond_neg(quo_acc, q_neg);
                    remainder <= cond_neg(rem_acc, r_neg);
                end
            end
        end
    end

endmodule
